// File: rtl/decode_scoreboard.sv
// decode_scoreboard: GPR write-hazard scoreboard and mul/div unit sequencer for the decode stage.
// Optional macro DECODE_SB_WB_BYPASS_EN: a same-cycle writeback of the last pending write clears the source hazard.
module decode_scoreboard #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned CNTW  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [5:0]       id_rs1,
    input  logic [5:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [5:0]       id_rd,
    input  logic             id_rd_we,
    input  logic             id_multicycle,
    input  logic             md_done,
    input  logic             wb_valid,
    input  logic [5:0]       wb_rd,
    output logic             sb_stall,
    output logic             id_issue,
    output logic             md_busy,
    output logic [NREGS-1:0] sb_pending,
    output logic             sb_err
);

    localparam int unsigned RW = $clog2(NREGS);
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

    md_state_e         state_q, state_d;
    logic [CNTW-1:0]   cnt_q [NREGS];
    logic [CNTW-1:0]   cnt_d [NREGS];
    logic [NREGS-1:0]  pending_q, pending_d;
    logic              err_q, err_d;

    logic [RW-1:0]     rs1_n, rs2_n, rd_n, wb_n;
    logic              src1_haz, src2_haz, waw_haz, md_haz;
    logic              idx_err, wb_err, md_err;

    function automatic logic in_range(input logic [5:0] idx);
        return 32'(idx) < NREGS;
    endfunction

    // Out-of-range indices alias onto the hardwired-zero register.
    function automatic logic [RW-1:0] norm_idx(input logic [5:0] idx);
        return in_range(idx) ? RW'(idx) : '0;
    endfunction

    assign md_busy    = (state_q == MD_BUSY);
    assign sb_pending = pending_q;
    assign sb_err     = err_q;

    // Zero-latency hazard detection and issue handshake.
    always_comb begin
        rs1_n    = norm_idx(id_rs1);
        rs2_n    = norm_idx(id_rs2);
        rd_n     = norm_idx(id_rd);
        wb_n     = norm_idx(wb_rd);
        src1_haz = id_rs1_used && (cnt_q[rs1_n] != '0);
        src2_haz = id_rs2_used && (cnt_q[rs2_n] != '0);
`ifdef DECODE_SB_WB_BYPASS_EN
        if (wb_valid && (wb_n == rs1_n) && (cnt_q[rs1_n] == CNT_ONE)) begin
            src1_haz = 1'b0;
        end
        if (wb_valid && (wb_n == rs2_n) && (cnt_q[rs2_n] == CNT_ONE)) begin
            src2_haz = 1'b0;
        end
`endif
        waw_haz  = id_rd_we && (rd_n != '0) && (cnt_q[rd_n] == CNT_MAX);
        md_haz   = id_multicycle && md_busy && !md_done;
        sb_stall = id_valid && (src1_haz || src2_haz || waw_haz || md_haz);
        id_issue = id_valid && !sb_stall;
    end

    // Next-state: counters, mul/div FSM, pending mirror and sticky error.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = '0;
        idx_err   = id_valid && ((id_rs1_used && !in_range(id_rs1)) ||
                                 (id_rs2_used && !in_range(id_rs2)) ||
                                 (id_rd_we    && !in_range(id_rd)));
        wb_err    = wb_valid && (wb_rd != '0) && (cnt_q[wb_n] == '0);
        md_err    = md_done && (state_q == MD_IDLE);
        err_d     = err_q || idx_err || wb_err || md_err;

        for (int r = 1; r < int'(NREGS); r++) begin
            if (id_issue && id_rd_we && (rd_n == RW'(r)) && !(wb_valid && (wb_n == RW'(r)))) begin
                cnt_d[RW'(r)] = cnt_q[RW'(r)] + CNT_ONE;
            end else if (wb_valid && (wb_n == RW'(r)) && !(id_issue && id_rd_we && (rd_n == RW'(r)))
                         && (cnt_q[RW'(r)] != '0)) begin
                cnt_d[RW'(r)] = cnt_q[RW'(r)] - CNT_ONE;
            end
        end
        cnt_d[0] = '0;

        for (int r = 0; r < int'(NREGS); r++) begin
            pending_d[r] = (cnt_d[RW'(r)] != '0);
        end

        case (state_q)
            MD_IDLE: if (id_issue && id_multicycle) state_d = MD_BUSY;
            MD_BUSY: if (md_done && !(id_issue && id_multicycle)) state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= MD_IDLE;
            pending_q <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < int'(NREGS); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_decode_scoreboard.sv
// tb_decode_scoreboard: scoreboard bench for decode_scoreboard; honours DECODE_SB_WB_BYPASS_EN.
module tb_decode_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_multicycle;
    logic        md_done, wb_valid;
    logic [5:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic        sb_stall, id_issue, md_busy, sb_err;
    logic [31:0] sb_pending;

    always #5 clk = ~clk;

    decode_scoreboard #(.NREGS(32), .CNTW(2)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_multicycle(id_multicycle),
        .md_done(md_done), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .sb_stall(sb_stall), .id_issue(id_issue), .md_busy(md_busy),
        .sb_pending(sb_pending), .sb_err(sb_err)
    );

    typedef struct packed {
        logic        stall;
        logic        issue;
        logic        busy;
        logic [31:0] pend;
        logic        err;
    } exp_t;

    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    m_cnt[32];
    bit    m_busy, m_err, m_stall, m_issue;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic int nidx(input logic [5:0] i);
        return (i < 6'd32) ? int'(i) : 0;
    endfunction

    function automatic logic [31:0] model_pend();
        logic [31:0] p = '0;
        for (int r = 1; r < 32; r++) p[r] = (m_cnt[r] != 0);
        return p;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_busy = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_eval();
        int  a, b, d;
        bit  s1, s2, waw, md;
        a  = nidx(id_rs1);
        b  = nidx(id_rs2);
        d  = nidx(id_rd);
        s1 = id_rs1_used && (m_cnt[a] != 0);
        s2 = id_rs2_used && (m_cnt[b] != 0);
`ifdef DECODE_SB_WB_BYPASS_EN
        if (wb_valid && nidx(wb_rd) == a && m_cnt[a] == 1) s1 = 1'b0;
        if (wb_valid && nidx(wb_rd) == b && m_cnt[b] == 1) s2 = 1'b0;
`endif
        waw     = id_rd_we && (d != 0) && (m_cnt[d] == 3);
        md      = id_multicycle && m_busy && !md_done;
        m_stall = id_valid && (s1 || s2 || waw || md);
        m_issue = id_valid && !m_stall;
    endtask

    task automatic model_update();
        int w, d;
        bit inc, dec;
        w = nidx(wb_rd);
        d = nidx(id_rd);
        if (wb_valid && wb_rd != 6'd0 && m_cnt[w] == 0) m_err = 1'b1;
        if (id_valid && ((id_rs1_used && id_rs1 >= 6'd32) || (id_rs2_used && id_rs2 >= 6'd32) ||
                         (id_rd_we && id_rd >= 6'd32))) m_err = 1'b1;
        if (md_done && !m_busy) m_err = 1'b1;
        inc = m_issue && id_rd_we && (d != 0);
        dec = wb_valid && (w != 0);
        if (inc && !(dec && w == d)) m_cnt[d]++;
        if (dec && !(inc && w == d) && m_cnt[w] > 0) m_cnt[w]--;
        if (!m_busy) m_busy = m_issue && id_multicycle;
        else if (md_done && !(m_issue && id_multicycle)) m_busy = 1'b0;
    endtask

    task automatic drive(input bit v, input logic [5:0] rs1, input bit u1, input logic [5:0] rs2,
                         input bit u2, input logic [5:0] rd, input bit we, input bit mc,
                         input bit mdd, input bit wbv, input logic [5:0] wbr);
        id_valid = v;  id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd;    id_rd_we = we; id_multicycle = mc; md_done = mdd;
        wb_valid = wbv; wb_rd = wbr;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One cycle from a negedge: push the model's expectation, compare, advance both across the edge.
    task automatic step(input string tag, input int want_stall);
        exp_t e;
        #1;
        model_eval();
        e.stall = m_stall; e.issue = m_issue; e.busy = m_busy;
        e.pend  = model_pend(); e.err = m_err;
        exp_q.push_back(e);
        e = exp_q.pop_front();
        check({tag, ".stall"}, 32'(sb_stall), 32'(e.stall));
        check({tag, ".issue"}, 32'(id_issue), 32'(e.issue));
        check({tag, ".busy"}, 32'(md_busy), 32'(e.busy));
        check({tag, ".pend"}, sb_pending, e.pend);
        check({tag, ".err"}, 32'(sb_err), 32'(e.err));
        if (want_stall >= 0) check({tag, ".plan"}, 32'(sb_stall), 32'(want_stall));
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        idle();
        model_reset();
        #12;
        check("rst.pend", sb_pending, 32'h0);
        check("rst.busy", 32'(md_busy), 32'h0);
        check("rst.err", 32'(sb_err), 32'h0);
        check("rst.stall", 32'(sb_stall), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // RAW hazard on r5 released by writeback
        step("idle0", 0);
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);   step("wr5", 0);
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);   step("raw5", 1);
        check("raw5.pend5", 32'(sb_pending[5]), 32'h1);
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 5);
`ifdef DECODE_SB_WB_BYPASS_EN
        step("raw5_wb", 0);
`else
        step("raw5_wb", 1);
`endif
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);   step("raw5_after", 0);
        check("raw5.pend5_clr", 32'(sb_pending[5]), 32'h0);

        // WAW saturation on r7
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0); step("wr7", 0);
        end
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);   step("waw_full", 1);
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 1, 7);   step("waw_full_wb", 1);
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 1, 7);   step("waw_wb_issue", 0);
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);   step("waw_refill", 0);
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);   step("waw_full2", 1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7); step("wb7", 0);
        end
        idle(); step("wb7_done", 0);
        check("wb7.pend7", 32'(sb_pending[7]), 32'h0);

        // mul/div sequencing
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);   step("mul1", 0);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);   step("mul2_stall", 1);
        check("mul.busy", 32'(md_busy), 32'h1);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);   step("mul2_done", 0);
        idle();                                   step("mul2_busy", 0);
        check("mul.busy_kept", 32'(md_busy), 32'h1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);   step("mul_done", 0);
        idle();                                   step("mul_idle", 0);
        check("mul.busy_clr", 32'(md_busy), 32'h0);

        // index 0 is never a hazard
        drive(1, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0);   step("zero", 0);
        idle();                                   step("zero_after", 0);
        check("zero.pend", sb_pending, 32'h0);
        check("zero.err", 32'(sb_err), 32'h0);

        // out-of-range source index
        drive(1, 40, 1, 0, 0, 0, 0, 0, 0, 0, 0);  step("oor", 0);
        idle();                                   step("oor_after", 0);
        check("oor.err", 32'(sb_err), 32'h1);

        reset = 1'b0; model_reset(); #1;
        check("rst2.err", 32'(sb_err), 32'h0);
        @(negedge clk); reset = 1'b1;

        // writeback to idle register
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);   step("wb9", 0);
        idle();                                   step("wb9_after", 0);
        check("wb9.err", 32'(sb_err), 32'h1);
        check("wb9.pend", sb_pending, 32'h0);

        // async reset mid-operation
        drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0);   step("mul_rd3", 0);
        idle(); #1;
        check("pre_rst.pend3", 32'(sb_pending[3]), 32'h1);
        check("pre_rst.busy", 32'(md_busy), 32'h1);
        reset = 1'b0; model_reset(); #1;
        check("arst.pend", sb_pending, 32'h0);
        check("arst.busy", 32'(md_busy), 32'h0);
        check("arst.err", 32'(sb_err), 32'h0);
        @(negedge clk); reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3);   step("late_wb3", 0);
        idle();                                   step("late_wb3_after", 0);
        check("late_wb3.err", 32'(sb_err), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
